// File: rtl/mgmt_initiator_pkg.sv
// Shared definitions for the management bus initiator and the responders on the same bus.
// Holds state encodings, responder address windows and the decode helper.
package mgmt_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Responder address windows: system registers and memory-controller config
    localparam logic [31:0] SYSREG_BASE = 32'h0000_0000;
    localparam logic [31:0] SYSREG_MASK = 32'hFFFF_F000;
    localparam logic [31:0] MCCFG_BASE  = 32'h4000_0000;
    localparam logic [31:0] MCCFG_MASK  = 32'hFFFF_0000;

    localparam int TMR_W = 8;

    function automatic logic adr_hit(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
        return (adr & mask) == base;
    endfunction

endpackage

// File: rtl/mgmt_initiator_timer.sv
// Loadable up-counter with a terminal-count flag; done is high while the
// count equals last, i.e. during the (last+1)-th enabled cycle after a load.
module mgmt_initiator_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign done = (count_reg == last);

endmodule

// File: rtl/mgmt_initiator.sv
// Management bus master: one core command in, one mgmt bus transaction out,
// one response pulse back, with request timeout and an enforced idle gap.
module mgmt_initiator
    import mgmt_initiator_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int GAP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic [31:0] cmd_adr,
    input  logic        cmd_rwn,
    input  logic [1:0]  cmd_wen,
    input  logic [31:0] cmd_txd,
    output logic        rsp_vld,
    output logic        rsp_err,
    output logic [31:0] rsp_rxd,
    output logic        mgmt_req,
    output logic [31:0] mgmt_adr,
    output logic        mgmt_rwn,
    output logic [1:0]  mgmt_wen,
    output logic [31:0] mgmt_txd,
    input  logic        mgmt_ack,
    input  logic        mgmt_rxe,
    input  logic [31:0] mgmt_rxd,
    output logic [7:0]  err_cnt
);

    localparam int N_TMR   = 2;
    localparam int TMR_TO  = 0;
    localparam int TMR_GAP = 1;

    state_t      state_reg;
    logic        cmd_rdy_reg;
    logic        rsp_vld_reg;
    logic        rsp_err_reg;
    logic [31:0] rsp_rxd_reg;
    logic        mgmt_req_reg;
    logic [31:0] mgmt_adr_reg;
    logic        mgmt_rwn_reg;
    logic [1:0]  mgmt_wen_reg;
    logic [31:0] mgmt_txd_reg;
    logic [7:0]  err_cnt_reg;

    logic [N_TMR-1:0] tmr_load;
    logic [N_TMR-1:0] tmr_en;
    logic [N_TMR-1:0] tmr_done;
    logic [TMR_W-1:0] tmr_last [N_TMR];

    // Timeout timer restarts on accept and counts every request cycle;
    // the gap timer is held clear while requesting and counts through GAP.
    assign tmr_last[TMR_TO]  = TMR_W'(TIMEOUT - 1);
    assign tmr_last[TMR_GAP] = TMR_W'(GAP - 1);
    assign tmr_load[TMR_TO]  = (state_reg == ST_IDLE) && cmd_vld;
    assign tmr_en[TMR_TO]    = (state_reg == ST_REQ);
    assign tmr_load[TMR_GAP] = (state_reg == ST_REQ);
    assign tmr_en[TMR_GAP]   = (state_reg == ST_GAP);

    generate
        for (genvar gi = 0; gi < N_TMR; gi++) begin : g_tmr
            mgmt_initiator_timer #(
                .W (TMR_W)
            ) u_tmr (
                .clk  (clk),
                .rst  (rst),
                .load (tmr_load[gi]),
                .en   (tmr_en[gi]),
                .last (tmr_last[gi]),
                .done (tmr_done[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cmd_rdy_reg  <= 1'b1;
            rsp_vld_reg  <= 1'b0;
            rsp_err_reg  <= 1'b0;
            rsp_rxd_reg  <= '0;
            mgmt_req_reg <= 1'b0;
            mgmt_adr_reg <= '0;
            mgmt_rwn_reg <= 1'b0;
            mgmt_wen_reg <= '0;
            mgmt_txd_reg <= '0;
            err_cnt_reg  <= '0;
        end else begin
            rsp_vld_reg <= 1'b0;
            rsp_err_reg <= 1'b0;
            rsp_rxd_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_vld) begin
                        mgmt_adr_reg <= cmd_adr;
                        mgmt_rwn_reg <= cmd_rwn;
                        mgmt_wen_reg <= cmd_rwn ? 2'b00 : cmd_wen;
                        mgmt_txd_reg <= cmd_txd;
                        mgmt_req_reg <= 1'b1;
                        cmd_rdy_reg  <= 1'b0;
                        state_reg    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An ack on the terminal-count cycle still completes cleanly
                    if (mgmt_ack) begin
                        mgmt_req_reg <= 1'b0;
                        rsp_vld_reg  <= 1'b1;
                        rsp_rxd_reg  <= (mgmt_rwn_reg && mgmt_rxe) ? mgmt_rxd : 32'h0;
                        state_reg    <= ST_GAP;
                    end else if (tmr_done[TMR_TO]) begin
                        mgmt_req_reg <= 1'b0;
                        rsp_vld_reg  <= 1'b1;
                        rsp_err_reg  <= 1'b1;
                        if (err_cnt_reg != 8'hFF) begin
                            err_cnt_reg <= err_cnt_reg + 8'd1;
                        end
                        state_reg    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmr_done[TMR_GAP]) begin
                        cmd_rdy_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end
                default: begin
                    mgmt_req_reg <= 1'b0;
                    cmd_rdy_reg  <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_rdy  = cmd_rdy_reg;
    assign rsp_vld  = rsp_vld_reg;
    assign rsp_err  = rsp_err_reg;
    assign rsp_rxd  = rsp_rxd_reg;
    assign mgmt_req = mgmt_req_reg;
    assign mgmt_adr = mgmt_adr_reg;
    assign mgmt_rwn = mgmt_rwn_reg;
    assign mgmt_wen = mgmt_wen_reg;
    assign mgmt_txd = mgmt_txd_reg;
    assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_mgmt_initiator.sv
// Scoreboard bench for mgmt_initiator: directed and random commands, a
// responder model on the bus, and a monitor comparing every response.
module tb_mgmt_initiator;
    import mgmt_initiator_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int GAP     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [31:0] cmd_adr = '0;
    logic        cmd_rwn = 1'b0;
    logic [1:0]  cmd_wen = '0;
    logic [31:0] cmd_txd = '0;
    logic        rsp_vld;
    logic        rsp_err;
    logic [31:0] rsp_rxd;
    logic        mgmt_req;
    logic [31:0] mgmt_adr;
    logic        mgmt_rwn;
    logic [1:0]  mgmt_wen;
    logic [31:0] mgmt_txd;
    logic        mgmt_ack = 1'b0;
    logic        mgmt_rxe = 1'b0;
    logic [31:0] mgmt_rxd = '0;
    logic [7:0]  err_cnt;

    mgmt_initiator #(
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_adr  (cmd_adr),
        .cmd_rwn  (cmd_rwn),
        .cmd_wen  (cmd_wen),
        .cmd_txd  (cmd_txd),
        .rsp_vld  (rsp_vld),
        .rsp_err  (rsp_err),
        .rsp_rxd  (rsp_rxd),
        .mgmt_req (mgmt_req),
        .mgmt_adr (mgmt_adr),
        .mgmt_rwn (mgmt_rwn),
        .mgmt_wen (mgmt_wen),
        .mgmt_txd (mgmt_txd),
        .mgmt_ack (mgmt_ack),
        .mgmt_rxe (mgmt_rxe),
        .mgmt_rxd (mgmt_rxd),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // What the responder should see and do for one transaction
    typedef struct {
        logic [31:0] adr;
        logic        rwn;
        logic [1:0]  wen;
        logic [31:0] txd;
        int          d;
        logic        rxe;
        logic [31:0] data;
        logic        noise;
        logic        late;
        int          exp_len;
    } bus_t;

    typedef struct {
        logic        err;
        logic [31:0] rxd;
        logic [7:0]  ecnt;
        int          cyc;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   model_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic claimed_adr(input logic [31:0] adr);
        return adr_hit(adr, SYSREG_BASE, SYSREG_MASK) || adr_hit(adr, MCCFG_BASE, MCCFG_MASK);
    endfunction

    // Called at a negedge; returns at the negedge right after acceptance.
    task automatic issue(input logic [31:0] adr, input logic rwn, input logic [1:0] wen,
                         input logic [31:0] txd, input int d, input logic rxe,
                         input logic [31:0] data, input logic noise, input logic late,
                         input logic abort);
        bus_t b;
        rsp_t r;
        logic acked;
        int   len;
        int   waitn;
        cmd_vld = 1'b1;
        cmd_adr = adr;
        cmd_rwn = rwn;
        cmd_wen = wen;
        cmd_txd = txd;
        waitn = 0;
        while (cmd_rdy !== 1'b1 && waitn < 200) begin
            @(negedge clk);
            waitn++;
        end
        if (cmd_rdy !== 1'b1) begin
            chk("accept_wait", {31'b0, cmd_rdy}, 32'd1);
            cmd_vld = 1'b0;
            return;
        end
        acked = claimed_adr(adr) && (d + 1 <= TIMEOUT);
        len   = acked ? d + 1 : TIMEOUT;
        b.adr = adr;
        b.rwn = rwn;
        b.wen = rwn ? 2'b00 : wen;
        b.txd = txd;
        b.d = d;
        b.rxe = rxe;
        b.data = data;
        b.noise = noise;
        b.late = late;
        b.exp_len = abort ? -1 : len;
        bus_q.push_back(b);
        if (!abort) begin
            if (!acked && model_err < 255) model_err++;
            r.err  = !acked;
            r.rxd  = (acked && rwn && rxe) ? data : 32'h0;
            r.ecnt = 8'(model_err);
            r.cyc  = cyc + len + 1;
            rsp_q.push_back(r);
        end
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    // Responder model: decodes the windows and acks d cycles after first seeing req
    bus_t cur;
    logic rs_busy = 1'b0;
    logic rs_claim = 1'b0;
    int   rs_hi = 0;
    int   rs_last_fall = -1;

    initial begin : responder
        forever begin
            @(negedge clk);
            mgmt_ack = 1'b0;
            mgmt_rxe = 1'b0;
            mgmt_rxd = '0;
            if (mgmt_req === 1'b1 && !rs_busy) begin
                rs_busy = 1'b1;
                rs_hi = 1;
                if (bus_q.size() == 0) begin
                    chk("req_without_cmd", 32'd1, 32'd0);
                    rs_claim = 1'b0;
                    cur.exp_len = -1;
                    cur.late = 1'b0;
                end else begin
                    cur = bus_q.pop_front();
                    chk("mgmt_adr", mgmt_adr, cur.adr);
                    chk("mgmt_rwn", {31'b0, mgmt_rwn}, {31'b0, cur.rwn});
                    chk("mgmt_wen", {30'b0, mgmt_wen}, {30'b0, cur.wen});
                    chk("mgmt_txd", mgmt_txd, cur.txd);
                    if (rs_last_fall >= 0)
                        chk("gap_low_at_least", {31'b0, (cyc - rs_last_fall - 1) >= GAP + 1}, 32'd1);
                    rs_claim = claimed_adr(mgmt_adr);
                end
            end else if (mgmt_req === 1'b1) begin
                rs_hi++;
            end else if (rs_busy) begin
                rs_busy = 1'b0;
                if (cur.exp_len >= 0) chk("req_high_cycles", rs_hi, cur.exp_len);
                rs_last_fall = cyc - 1;
                if (cur.late) begin
                    mgmt_ack = 1'b1;
                    mgmt_rxe = 1'b1;
                    mgmt_rxd = $urandom;
                end
            end
            if (rs_busy && rs_claim) begin
                if (rs_hi == cur.d + 1) begin
                    mgmt_ack = 1'b1;
                    mgmt_rxe = cur.rxe;
                    mgmt_rxd = cur.rxe ? cur.data : 32'h0;
                end else if (cur.noise && rs_hi <= cur.d) begin
                    mgmt_rxe = 1'b1;
                    mgmt_rxd = $urandom;
                end
            end
        end
    end

    rsp_t mon_e;
    int   rdy_target = -1;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rsp_vld === 1'b1) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp_vld", 32'd1, 32'd0);
                end else begin
                    mon_e = rsp_q.pop_front();
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
                    chk("rsp_rxd", rsp_rxd, mon_e.rxd);
                    chk("err_cnt", {24'b0, err_cnt}, {24'b0, mon_e.ecnt});
                    chk("rsp_cycle", cyc, mon_e.cyc);
                    chk("cmd_rdy_at_rsp", {31'b0, cmd_rdy}, 32'd0);
                    rdy_target = cyc + GAP;
                end
            end
            if (rdy_target >= 0 && (cmd_rdy === 1'b1 || cyc >= rdy_target + 8)) begin
                chk("cmd_rdy_return_cycle", cyc, rdy_target);
                rdy_target = -1;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          waitn;
        int          sel;
        logic [31:0] adr;
        repeat (3) @(negedge clk);
        chk("reset_cmd_rdy", {31'b0, cmd_rdy}, 32'd1);
        chk("reset_mgmt_req", {31'b0, mgmt_req}, 32'd0);
        chk("reset_mgmt_adr", mgmt_adr, 32'd0);
        chk("reset_mgmt_txd", mgmt_txd, 32'd0);
        chk("reset_mgmt_wen_rwn", {29'b0, mgmt_wen, mgmt_rwn}, 32'd0);
        chk("reset_rsp", {31'b0, rsp_vld | rsp_err}, 32'd0);
        chk("reset_rsp_rxd", rsp_rxd, 32'd0);
        chk("reset_err_cnt", {24'b0, err_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(32'h0000_0002, 1'b1, 2'b11, 32'h0, 2, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        issue(32'h4000_0010, 1'b0, 2'b01, 32'h1234_5678, 1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(32'h4000_0020, 1'b0, 2'b10, 32'hCAFE_F00D, 0, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
        issue(32'h0000_0100, 1'b1, 2'b00, 32'h0, 4, 1'b1, 32'h0BAD_C0DE, 1'b1, 1'b0, 1'b0);
        issue(32'h8000_0000, 1'b1, 2'b00, 32'h0, 0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 1'b0);
        issue(32'h0000_0004, 1'b1, 2'b00, 32'h0, 1, 1'b1, 32'hA1A2_A3A4, 1'b0, 1'b0, 1'b0);
        issue(32'h0000_0008, 1'b1, 2'b00, 32'h0, 1, 1'b1, 32'hB1B2_B3B4, 1'b0, 1'b0, 1'b0);
        issue(32'h0000_0010, 1'b1, 2'b00, 32'h0, TIMEOUT - 1, 1'b1, 32'h7777_0001, 1'b0, 1'b0, 1'b0);
        issue(32'h0000_0014, 1'b1, 2'b00, 32'h0, TIMEOUT, 1'b1, 32'h7777_0002, 1'b0, 1'b1, 1'b0);

        // Random traffic over all windows and unclaimed space
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0)      adr = $urandom & 32'h0000_0FFF;
            else if (sel == 1) adr = 32'h4000_0000 | ($urandom & 32'h0000_FFFF);
            else               adr = 32'h8000_0000 | ($urandom & 32'h00FF_FFFF);
            issue(adr, 1'($urandom), 2'($urandom), $urandom, $urandom_range(0, 20),
                  1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'b0);
        end

        // Enough timeouts to saturate the error counter
        for (int i = 0; i < 300; i++) begin
            issue(32'h9000_0000 + i, 1'b1, 2'b00, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'($urandom), 1'b0);
        end
        waitn = 0;
        while (rsp_q.size() != 0 && waitn < 500) begin
            @(negedge clk);
            waitn++;
        end
        chk("rsp_queue_drained", rsp_q.size(), 32'd0);
        repeat (4) @(negedge clk);
        chk("err_cnt_saturated", {24'b0, err_cnt}, 32'd255);

        // Reset in the middle of a request
        issue(32'h8800_0000, 1'b1, 2'b00, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_err = 0;
        chk("rst_mid_mgmt_req", {31'b0, mgmt_req}, 32'd0);
        chk("rst_mid_cmd_rdy", {31'b0, cmd_rdy}, 32'd1);
        chk("rst_mid_rsp_vld", {31'b0, rsp_vld}, 32'd0);
        chk("rst_mid_err_cnt", {24'b0, err_cnt}, 32'd0);
        repeat (40) @(negedge clk);

        issue(32'h0000_0020, 1'b1, 2'b00, 32'h0, 0, 1'b1, 32'h600D_0001, 1'b0, 1'b0, 1'b0);
        issue(32'h8000_1000, 1'b0, 2'b11, 32'hFFFF_0000, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        waitn = 0;
        while (rsp_q.size() != 0 && waitn < 200) begin
            @(negedge clk);
            waitn++;
        end
        chk("final_rsp_queue_drained", rsp_q.size(), 32'd0);
        repeat (10) @(negedge clk);
        chk("final_bus_queue_empty", bus_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
